// File: rtl/aurora_pkg.sv
// Shared symbol constants, lane word type and FSM encodings for the Aurora
// simplex TX framing layer.
package aurora_pkg;

  localparam logic [7:0] K_IDLE  = 8'hBC;
  localparam logic [7:0] K_ALIGN = 8'h7C;
  localparam logic [7:0] K_R     = 8'h1C;
  localparam logic [7:0] K_CC    = 8'hF7;
  localparam logic [7:0] SCP0    = 8'h5C;
  localparam logic [7:0] SCP1    = 8'hFB;
  localparam logic [7:0] ECP0    = 8'hFD;
  localparam logic [7:0] ECP1    = 8'hFE;

  // ctrl[1] flags data[15:8], the first byte on the wire.
  typedef struct packed {
    logic [1:0]  ctrl;
    logic [15:0] data;
  } lane_word_t;

  typedef enum logic [1:0] {ALIGN, BOND, VERIFY, READY} init_state_t;
  typedef enum logic [1:0] {F_IDLE, F_SCP, F_DATA, F_ECP} frame_state_t;

  function automatic lane_word_t k_pair(input logic [7:0] b0, input logic [7:0] b1);
    return '{ctrl: 2'b11, data: {b0, b1}};
  endfunction

  function automatic lane_word_t init_word(input init_state_t s);
    case (s)
      ALIGN:   return k_pair(K_IDLE, K_R);
      BOND:    return k_pair(K_ALIGN, K_IDLE);
      VERIFY:  return k_pair(K_ALIGN, K_R);
      default: return k_pair(K_IDLE, K_IDLE);
    endcase
  endfunction

endpackage

// File: rtl/aurora_cc_scheduler.sv
// Free-running clock-compensation timer; cc_active is high for CC_LEN cycles
// following every counter wrap.
module aurora_cc_scheduler #(
  parameter int CC_PERIOD = 5000,
  parameter int CC_LEN    = 3
) (
  input  logic clk,
  input  logic rst,
  output logic cc_active
);

  localparam int CW = (CC_PERIOD > 1) ? $clog2(CC_PERIOD) : 1;
  localparam int RW = $clog2(CC_LEN + 1);

  logic [CW-1:0] count;
  logic [RW-1:0] cc_remaining;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count        <= '0;
      cc_remaining <= '0;
    end else if (count == CW'(CC_PERIOD - 1)) begin
      count        <= '0;
      cc_remaining <= RW'(CC_LEN);
    end else begin
      count <= count + CW'(1);
      if (cc_remaining != '0) cc_remaining <= cc_remaining - RW'(1);
    end
  end

  assign cc_active = (cc_remaining != '0);

endmodule

// File: rtl/aurora_tx_channel.sv
// Simplex Aurora TX channel: init sequencing, SCP/ECP framing, lane striping
// and CC insertion, with one registered lane word per lane.
module aurora_tx_channel
  import aurora_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int CC_PERIOD = 5000,
  parameter int CC_LEN    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  input  logic [16*LANES-1:0]  s_axis_tdata,
  input  logic                 simplex_aligned,
  input  logic                 simplex_bonded,
  input  logic                 simplex_verified,
  input  logic                 simplex_reset,
  output logic [2*LANES-1:0]   lane_ctrl,
  output logic [16*LANES-1:0]  lane_data,
  output logic                 channel_up
);

  init_state_t  init_state, init_next;
  frame_state_t frame_state, frame_next;
  lane_word_t   lane_q [LANES];
  lane_word_t   lane_d [LANES];
  logic         cc_active;
  logic         accept;

  aurora_cc_scheduler #(
    .CC_PERIOD (CC_PERIOD),
    .CC_LEN    (CC_LEN)
  ) u_cc (
    .clk       (clk),
    .rst       (rst),
    .cc_active (cc_active)
  );

  // Built from registered state only, so tvalid never reaches tready.
  assign s_axis_tready = (init_state == READY) && (frame_state == F_DATA) && !cc_active;
  assign channel_up    = (init_state == READY);
  assign accept        = s_axis_tvalid && s_axis_tready;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    init_next = init_state;
    if (simplex_reset) begin
      init_next = ALIGN;
    end else begin
      case (init_state)
        ALIGN:  if (simplex_aligned) begin
                  if (LANES == 1) init_next = VERIFY;
                  else            init_next = BOND;
                end
        BOND:   if (simplex_bonded)   init_next = VERIFY;
        VERIFY: if (simplex_verified) init_next = READY;
        default: ;
      endcase
    end
  end

  always_comb begin
    frame_next = frame_state;
    for (int i = 0; i < LANES; i++) lane_d[i] = k_pair(K_IDLE, K_IDLE);

    if (init_state != READY || init_next != READY) begin
      // Leaving or not yet in READY: any open frame is dropped without ECP.
      frame_next = F_IDLE;
      for (int i = 0; i < LANES; i++) lane_d[i] = init_word(init_next);
    end else if (!cc_active) begin
      case (frame_state)
        F_IDLE: if (s_axis_tvalid) frame_next = F_SCP;
        F_SCP: begin
          lane_d[0]  = k_pair(SCP0, SCP1);
          frame_next = F_DATA;
        end
        F_DATA: if (accept) begin
          for (int i = 0; i < LANES; i++)
            lane_d[i] = '{ctrl: 2'b00, data: s_axis_tdata[16*i +: 16]};
          if (s_axis_tlast) frame_next = F_ECP;
        end
        F_ECP: begin
          lane_d[0]  = k_pair(ECP0, ECP1);
          frame_next = F_IDLE;
        end
        default: frame_next = F_IDLE;
      endcase
    end

    // CC overrides whatever the framing logic chose; the frame FSM holds.
    if (cc_active)
      for (int i = 0; i < LANES; i++) lane_d[i] = k_pair(K_CC, K_CC);
  end

  // NOTE: the lane output array is a handful of flops, not a RAM, so it is
  // reset like any other register to put /K/ /K/ on the wire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_state  <= ALIGN;
      frame_state <= F_IDLE;
      for (int i = 0; i < LANES; i++) lane_q[i] <= k_pair(K_IDLE, K_IDLE);
    end else begin
      init_state  <= init_next;
      frame_state <= frame_next;
      lane_q      <= lane_d;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane_out
    assign lane_ctrl[2*g +: 2]  = lane_q[g].ctrl;
    assign lane_data[16*g +: 16] = lane_q[g].data;
  end

endmodule
